// File: rtl/proc_pkg.sv
// Shared definitions for the writeback/storage stage.
// Opcodes the stage decodes, default datapath widths, and the load FSM state type.
package proc_pkg;

  localparam int unsigned OP_W         = 4;
  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_RF_AW    = 3;
  localparam int unsigned DEF_DM_AW    = 4;

  localparam logic [OP_W-1:0] OP_LOAD  = 4'b1110;
  localparam logic [OP_W-1:0] OP_STORE = 4'b1111;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } wb_state_t;

endpackage : proc_pkg

// File: rtl/reg_file.sv
// Register file: one synchronous write port, two combinational read ports.
// Ports:
//   clk, rst_n            clock, async active-low clear of all entries
//   we_i/waddr_i/wdata_i  write port
//   raddr_a_i/raddr_b_i   read addresses
//   rdata_a_o/rdata_b_o   read data (combinational; optional same-cycle write forward)
module reg_file #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned AW     = 3,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array with async clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports; forward the write committing at the coming edge when enabled
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    rdata_b_o = mem_q[raddr_b_i];
    if (BYPASS && we_i && (waddr_i == raddr_a_i)) rdata_a_o = wdata_i;
    if (BYPASS && we_i && (waddr_i == raddr_b_i)) rdata_b_o = wdata_i;
  end

endmodule : reg_file

// File: rtl/reg_mem_wb.sv
// Writeback/storage stage: register file, data memory, and the load FSM.
// The execution unit's opcode/dest/store address arrive one cycle ahead of its
// registered strobes, so they are re-aligned here before the commit decision.
// Ports:
//   clk, reset                    clock, async active-low reset
//   rd_a_addr/rd_b_addr           operand read addresses -> operandA/operandB
//   ld_addr                       data-memory load address (with load opcode)
//   opcode_in/dest_in/st_addr_in  combinational instruction fields
//   result_in/wr_en_in            registered ALU result / register write strobe
//   st_data_in/st_en_in           registered store data / store strobe
//   dbg_dm_addr/dbg_dm_data       debug data-memory read
//   stall                         control unit must hold issue
module reg_mem_wb
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned RF_AW  = DEF_RF_AW,
  parameter int unsigned DM_AW  = DEF_DM_AW,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RF_AW-1:0]  rd_a_addr,
  input  logic [RF_AW-1:0]  rd_b_addr,
  input  logic [DM_AW-1:0]  ld_addr,
  input  logic [OP_W-1:0]   opcode_in,
  input  logic [RF_AW-1:0]  dest_in,
  input  logic [DM_AW-1:0]  st_addr_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic              wr_en_in,
  input  logic [DATA_W-1:0] st_data_in,
  input  logic              st_en_in,
  input  logic [DM_AW-1:0]  dbg_dm_addr,
  output logic [DATA_W-1:0] operandA,
  output logic [DATA_W-1:0] operandB,
  output logic              stall,
  output logic [DATA_W-1:0] dbg_dm_data
);

  localparam int unsigned DM_DEPTH = 1 << DM_AW;

  logic [OP_W-1:0]   op_q;
  logic [RF_AW-1:0]  dest_q;
  logic [DM_AW-1:0]  st_addr_q;
  logic [DM_AW-1:0]  ld_addr_q;

  wb_state_t         state_q, state_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic [RF_AW-1:0]  ld_dest_q, ld_dest_d;
  logic              skid_valid_q, skid_valid_d;
  logic [RF_AW-1:0]  skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic [DATA_W-1:0] dm_q [DM_DEPTH];

  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              alu_wr;
  logic              load_req;
  logic              load_drop;

  assign alu_wr   = wr_en_in && (op_q != OP_LOAD);
  assign load_req = wr_en_in && (op_q == OP_LOAD);

  // Alignment registers: pair each strobe with the previous cycle's fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= '0;
      dest_q    <= '0;
      st_addr_q <= '0;
      ld_addr_q <= '0;
    end else begin
      op_q      <= opcode_in;
      dest_q    <= dest_in;
      st_addr_q <= st_addr_in;
      ld_addr_q <= ld_addr;
    end
  end

  // FSM and skid state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ld_data_q    <= '0;
      ld_dest_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_addr_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ld_data_q    <= ld_data_d;
      ld_dest_q    <= ld_dest_d;
      skid_valid_q <= skid_valid_d;
      skid_addr_q  <= skid_addr_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // Next state and single write-port arbitration: load > skid > new ALU write
  always_comb begin
    state_d      = state_q;
    ld_data_d    = ld_data_q;
    ld_dest_d    = ld_dest_q;
    skid_valid_d = skid_valid_q;
    skid_addr_d  = skid_addr_q;
    skid_data_d  = skid_data_q;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    load_drop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (skid_valid_q) begin
          rf_we        = 1'b1;
          rf_waddr     = skid_addr_q;
          rf_wdata     = skid_data_q;
          skid_valid_d = 1'b0;
          // A fresh ALU write loses the port this edge; keep it in the skid
          if (alu_wr) begin
            skid_valid_d = 1'b1;
            skid_addr_d  = dest_q;
            skid_data_d  = result_in;
          end
          load_drop = load_req;
        end else if (alu_wr) begin
          rf_we    = 1'b1;
          rf_waddr = dest_q;
          rf_wdata = result_in;
        end else if (load_req) begin
          ld_data_d = dm_q[ld_addr_q];
          ld_dest_d = dest_q;
          state_d   = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        rf_we    = 1'b1;
        rf_waddr = ld_dest_q;
        rf_wdata = ld_data_q;
        state_d  = IDLE;
        if (alu_wr) begin
          skid_valid_d = 1'b1;
          skid_addr_d  = dest_q;
          skid_data_d  = result_in;
        end
        load_drop = load_req;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = (state_q == LOAD_WAIT) | skid_valid_q;

  // Data memory; stores commit independently of the register-file path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DM_DEPTH; i++) dm_q[i] <= '0;
    end else if (st_en_in) begin
      dm_q[st_addr_q] <= st_data_in;
    end
  end

  assign dbg_dm_data = dm_q[dbg_dm_addr];

  // A load strobe while the write path is still busy is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!load_drop) else $error("reg_mem_wb: load strobe dropped while busy");
    end
  end

  reg_file #(
    .DATA_W (DATA_W),
    .AW     (RF_AW),
    .BYPASS (BYPASS)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rd_a_addr),
    .raddr_b_i (rd_b_addr),
    .rdata_a_o (operandA),
    .rdata_b_o (operandB)
  );

endmodule : reg_mem_wb

// File: tb/tb_reg_mem_wb.sv
// Directed bench for reg_mem_wb: reset, ALU writes, stores, loads, load+skid,
// reset during a load, and boundary addresses.
module tb_reg_mem_wb;

  logic       clk;
  logic       reset;
  logic [2:0] rd_a_addr, rd_b_addr;
  logic [3:0] ld_addr;
  logic [3:0] opcode_in;
  logic [2:0] dest_in;
  logic [3:0] st_addr_in;
  logic [7:0] result_in;
  logic       wr_en_in;
  logic [7:0] st_data_in;
  logic       st_en_in;
  logic [3:0] dbg_dm_addr;
  logic [7:0] operandA, operandB;
  logic       stall;
  logic [7:0] dbg_dm_data;

  int n_vec  = 0;
  int n_miss = 0;

  reg_mem_wb dut (
    .clk         (clk),
    .reset       (reset),
    .rd_a_addr   (rd_a_addr),
    .rd_b_addr   (rd_b_addr),
    .ld_addr     (ld_addr),
    .opcode_in   (opcode_in),
    .dest_in     (dest_in),
    .st_addr_in  (st_addr_in),
    .result_in   (result_in),
    .wr_en_in    (wr_en_in),
    .st_data_in  (st_data_in),
    .st_en_in    (st_en_in),
    .dbg_dm_addr (dbg_dm_addr),
    .operandA    (operandA),
    .operandB    (operandB),
    .stall       (stall),
    .dbg_dm_data (dbg_dm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one cycle's worth of execution-unit outputs
  task automatic drive(input logic [3:0] op, input logic [2:0] dest, input logic [3:0] sta,
                       input logic [3:0] lda, input logic we, input logic [7:0] res,
                       input logic se, input logic [7:0] sd);
    opcode_in  = op;
    dest_in    = dest;
    st_addr_in = sta;
    ld_addr    = lda;
    wr_en_in   = we;
    result_in  = res;
    st_en_in   = se;
    st_data_in = sd;
  endtask

  task automatic idle();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a register on both ports; only call with no write strobe pending
  task automatic rd_rf(input string tag, input logic [2:0] a, input logic [7:0] exp);
    rd_a_addr = a;
    rd_b_addr = a;
    #1;
    check({tag, ".A"}, 32'(operandA), 32'(exp));
    check({tag, ".B"}, 32'(operandB), 32'(exp));
  endtask

  task automatic rd_dm(input string tag, input logic [3:0] a, input logic [7:0] exp);
    dbg_dm_addr = a;
    #1;
    check(tag, 32'(dbg_dm_data), 32'(exp));
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) rd_rf($sformatf("%s.rf%0d", tag, i), 3'(i), 8'h00);
    for (int i = 0; i < 16; i++) rd_dm($sformatf("%s.dm%0d", tag, i), 4'(i), 8'h00);
    check({tag, ".stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; dbg_dm_addr = '0;
    idle();

    // 1. reset state
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();
    check("rel.stall", 32'(stall), 32'd0);

    // 2. ALU write rf[3]=5A with same-cycle bypass
    drive(4'h1, 3'd3, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'h5A, 1'b0, 8'h00);
    rd_a_addr = 3'd3;
    #1;
    check("alu.bypass", 32'(operandA), 32'h5A);
    tick();
    idle();
    rd_rf("alu.rf3", 3'd3, 8'h5A);

    // 3. store C3 to dm[9], then load it into rf[6]
    drive(4'hF, 3'd0, 4'd9, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 8'hC3);
    tick();
    idle();
    rd_dm("st.dm9", 4'd9, 8'hC3);
    rd_rf("st.rf_untouched", 3'd0, 8'h00);
    drive(4'hE, 3'd6, 4'h0, 4'd9, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00);
    #1;
    check("ld.stall_pre", 32'(stall), 32'd0);
    tick();
    idle();
    #1;
    check("ld.stall_wait", 32'(stall), 32'd1);
    tick();
    check("ld.stall_done", 32'(stall), 32'd0);
    rd_rf("ld.rf6", 3'd6, 8'hC3);

    // 4. load (dm[4]=96 -> rf6) immediately followed by ALU write rf2=11
    drive(4'hF, 3'd0, 4'd4, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'hE, 3'd6, 4'h0, 4'd4, 1'b0, 8'h00, 1'b1, 8'h96);
    tick();
    drive(4'h1, 3'd2, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'h11, 1'b0, 8'h00);
    #1;
    check("skid.stall_wait", 32'(stall), 32'd1);
    tick();
    idle();
    #1;
    check("skid.stall_skid", 32'(stall), 32'd1);
    rd_a_addr = 3'd6;
    #1;
    check("skid.rf6_first", 32'(operandA), 32'h96);
    tick();
    check("skid.stall_done", 32'(stall), 32'd0);
    rd_rf("skid.rf2", 3'd2, 8'h11);
    rd_rf("skid.rf6", 3'd6, 8'h96);

    // 5. reset during LOAD_WAIT aborts the load into rf[4]
    drive(4'h1, 3'd4, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'hE, 3'd4, 4'h0, 4'd9, 1'b1, 8'h77, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'h00, 1'b0, 8'h00);
    rd_a_addr = 3'd4;
    #1;
    check("abort.rf4_pre", 32'(operandA), 32'h77);
    tick();
    idle();
    #1;
    check("abort.stall_wait", 32'(stall), 32'd1);
    reset = 1'b0;
    #1;
    check("abort.stall_rst", 32'(stall), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick();
    check_all_zero("abort");

    // 6. boundary addresses: dm[15], rf[7]
    drive(4'hF, 3'd0, 4'd15, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h2, 3'd7, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 8'hA5);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'hE7, 1'b0, 8'h00);
    tick();
    idle();
    rd_dm("bnd.dm15", 4'd15, 8'hA5);
    rd_dm("bnd.dm0", 4'd0, 8'h00);
    rd_rf("bnd.rf7", 3'd7, 8'hE7);
    rd_rf("bnd.rf0", 3'd0, 8'h00);

    // 7. write and store strobes at the same edge both commit
    drive(4'h3, 3'd1, 4'd2, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    drive(4'h0, 3'd0, 4'h0, 4'h0, 1'b1, 8'h42, 1'b1, 8'h24);
    tick();
    idle();
    rd_rf("both.rf1", 3'd1, 8'h42);
    rd_dm("both.dm2", 4'd2, 8'h24);
    check("both.stall", 32'(stall), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time bound on the run
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got no finish, expected finish");
    $fatal(1);
  end

endmodule : tb_reg_mem_wb

// File: doc/reg_mem_wb.md
Name: reg_mem_wb

Overview:
Writeback and storage stage that sits directly downstream of the execution unit. It holds the 8x8 register file and the 16x8 data memory. It supplies operandA/operandB back to the execution unit and commits the execution unit's registered writeback and store strobes. The execution unit's opcode, destination and store address are combinational, while its strobes are registered; this block re-aligns them. Loads (opcode 1110) read data memory and write the register file through a small FSM that stalls the control unit.

Parameters:
DATA_W, 8, datapath width
RF_AW, 3, register-file address width (8 entries)
DM_AW, 4, data-memory address width (16 entries)
BYPASS, 1, 1 = read ports forward a same-cycle register-file write

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
rd_a_addr  in  3  operand A read address (control unit)
rd_b_addr  in  3  operand B read address (control unit)
ld_addr  in  4  data-memory load address (control unit), valid with a load opcode
opcode_in  in  4  opcode from the execution unit (combinational, current instruction)
dest_in  in  3  destination register from the execution unit (combinational)
st_addr_in  in  4  store address from the execution unit (combinational)
result_in  in  8  registered ALU result
wr_en_in  in  1  registered register-file write strobe
st_data_in  in  8  registered store data
st_en_in  in  1  registered data-memory write strobe
dbg_dm_addr  in  4  debug data-memory read address
operandA  out  8  register-file read A
operandB  out  8  register-file read B
stall  out  1  control unit must not issue
dbg_dm_data  out  8  dmem[dbg_dm_addr], combinational

Behaviour:
- Alignment registers, captured every clock: op_q<=opcode_in, dest_q<=dest_in, st_addr_q<=st_addr_in, ld_addr_q<=ld_addr. All reset to 0. A strobe at edge E is always paired with the *_q values from the previous cycle.
- Reset (reset=0, async):
  - all register-file and data-memory entries = 0
  - state = IDLE; ld_data_q = 0; skid_valid = 0; stall = 0
  - operandA = operandB = 0, because storage is zero
- Reads: operandA = rf[rd_a_addr] and operandB = rf[rd_b_addr], combinational. With BYPASS=1, if the register-file write commit this cycle targets the same address, the read returns the write data.
- Commit classification at each rising edge (IDLE):
  - ALU write: wr_en_in=1 and op_q!=OP_LOAD -> rf[dest_q]<=result_in.
  - Load: wr_en_in=1 and op_q==OP_LOAD -> ld_data_q<=dm[ld_addr_q], ld_dest_q<=dest_q, state->LOAD_WAIT. No register-file write at this edge.
  - Store: st_en_in=1 -> dm[st_addr_q]<=st_data_in. A store never touches the register file.
  - If wr_en_in and st_en_in are both 1, both are committed. The execution unit never does this; the bench must still accept it.
- FSM:
  - IDLE --load--> LOAD_WAIT --(always)--> IDLE.
  - At the LOAD_WAIT exit edge: rf[ld_dest_q]<=ld_data_q, so a load commits 2 edges after its strobe.
  - If an ALU write strobe also arrives at that edge, it is captured in the one-entry skid (addr, data), skid_valid=1. It commits at the next edge, then skid_valid=0.
  - If a load strobe arrives at that edge or while skid_valid=1, it is a protocol violation. It is dropped, and an assertion fires in simulation.
  - A store arriving during LOAD_WAIT commits normally; the load has already sampled dm.
- stall = (state==LOAD_WAIT) | skid_valid, combinational from registers.
- Write-port priority at one edge: load commit > skid commit > new ALU write. The register file has a single write port.
- Reset asserted mid-load aborts the load: no register-file write, state=IDLE, skid cleared.
- Address widths are exact; no wrap logic is needed.

Decomposition:
- proc_pkg:
  - OP_LOAD = 4'b1110, OP_STORE = 4'b1111
  - DATA_W / RF_AW / DM_AW defaults
  - typedef wb_state_t {IDLE, LOAD_WAIT}
- One sub-module, reg_file: 8x8, one synchronous write port, two combinational read ports, BYPASS option, async active-low clear.
- Data memory, alignment registers, FSM and skid stay in reg_mem_wb.

Test Plan:
1. Reset then release; read all 8 registers and 16 dmem addresses -> all 0x00, stall=0.
2. ALU write: opcode_in=0001, dest_in=3 at cycle N; wr_en_in=1, result_in=0x5A at edge N+1 -> rf[3]=0x5A. With rd_a_addr=3 during cycle N+1, operandA=0x5A (bypass).
3. Store then load:
   - store: opcode 1111, st_addr=9, st_data 0xC3 -> dbg_dm_data@9 = 0xC3
   - load: opcode 1110, ld_addr=9, dest=6 -> stall high for exactly 1 cycle; rf[6]=0xC3 two edges after the strobe.
4. Load followed immediately by an ALU write (dest=2, 0x11) at the LOAD_WAIT exit edge:
   - rf[6] is committed first
   - stall stays 1 one more cycle
   - rf[2]=0x11 one edge later.
5. Assert reset while in LOAD_WAIT (ld target rf[4] pre-set to 0x77) -> all storage 0, state IDLE, stall=0, no late write to rf[4].
6. Store to address 15 and ALU write to rf[7] (boundary addresses) -> dm[15] and rf[7] updated; dm[0] and rf[0] unchanged.
